// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the miniRV fetch stage: state encoding, PC width
// and the reset-time constants.
package if_fetch_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] NOP_INST_WORD    = 32'h0000_0013;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding request to a variable-latency
// instruction memory, stale-response squashing on redirect, and an output slot.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_FETCH | no request in flight; issue when the output slot is free
//   ST_WAIT  | request in flight, response will be loaded into the slot
//   ST_KILL  | request in flight but redirected; drop its response
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] NOP_INST = NOP_INST_WORD
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            stall_IF,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] pc_IF_out,
    output logic [PC_W-1:0] pc4_IF_out,
    output logic [PC_W-1:0] inst_IF_out,
    output logic            inst_valid_IF_out
);

    fetch_state_t    state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n;
    logic [PC_W-1:0] req_pc, req_pc_n;
    logic [PC_W-1:0] slot_pc_n, slot_pc4_n, slot_inst_n;
    logic            slot_valid_n;
    logic [PC_W-1:0] redirect_aligned;
    logic            slot_free;

    assign redirect_aligned = redirect_pc & ~32'h0000_0003;
    assign slot_free        = !inst_valid_IF_out || !stall_IF;
    assign imem_addr        = fetch_pc;

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        req_pc_n     = req_pc;
        slot_valid_n = inst_valid_IF_out;
        slot_pc_n    = pc_IF_out;
        slot_pc4_n   = pc4_IF_out;
        slot_inst_n  = inst_IF_out;
        imem_req     = 1'b0;

        // A redirect empties the slot in every state, stalled or not.
        if (redirect_en) begin
            fetch_pc_n   = redirect_aligned;
            slot_valid_n = 1'b0;
            slot_inst_n  = NOP_INST;
        end

        case (state)
            ST_FETCH: begin
                if (!redirect_en && slot_free) begin
                    imem_req     = 1'b1;
                    req_pc_n     = fetch_pc;
                    fetch_pc_n   = fetch_pc + 32'd4;
                    slot_valid_n = 1'b0;
                    slot_inst_n  = NOP_INST;
                    state_n      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_en) begin
                    state_n = imem_rvalid ? ST_FETCH : ST_KILL;
                end else if (imem_rvalid) begin
                    slot_valid_n = 1'b1;
                    slot_pc_n    = req_pc;
                    slot_pc4_n   = req_pc + 32'd4;
                    slot_inst_n  = imem_rdata;
                    state_n      = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (imem_rvalid) begin
                    state_n = ST_FETCH;
                end
            end
            default: state_n = ST_FETCH;
        endcase

        if (cpu_rst) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state             <= ST_FETCH;
            fetch_pc          <= RESET_PC;
            req_pc            <= RESET_PC;
            inst_valid_IF_out <= 1'b0;
            pc_IF_out         <= '0;
            pc4_IF_out        <= 32'd4;
            inst_IF_out       <= NOP_INST;
        end else begin
            state             <= state_n;
            fetch_pc          <= fetch_pc_n;
            req_pc            <= req_pc_n;
            inst_valid_IF_out <= slot_valid_n;
            pc_IF_out         <= slot_pc_n;
            pc4_IF_out        <= slot_pc4_n;
            inst_IF_out       <= slot_inst_n;
        end
    end

    // A response with nothing in flight means the memory broke the protocol.
    a_no_rvalid_in_fetch: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(state == ST_FETCH && imem_rvalid))
        else $error("imem_rvalid while no request outstanding");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a variable-latency memory model,
// an address scoreboard and per-cycle slot checks.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        stall_IF;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IF_out;
    logic [31:0] pc4_IF_out;
    logic [31:0] inst_IF_out;
    logic        inst_valid_IF_out;

    if_fetch_unit dut (
        .cpu_clk           (cpu_clk),
        .cpu_rst           (cpu_rst),
        .stall_IF          (stall_IF),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .pc_IF_out         (pc_IF_out),
        .pc4_IF_out        (pc4_IF_out),
        .inst_IF_out       (inst_IF_out),
        .inst_valid_IF_out (inst_valid_IF_out)
    );

    always #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] addr_q[$];
    logic        seen_req;

    // Memory model: one pending request, answered lat cycles after issue.
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt  = 0;
    int          lat    = 1;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
        chk({tag, ".valid"}, {31'd0, inst_valid_IF_out}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk({tag, ".pc"}, pc_IF_out, exp_pc);
            chk({tag, ".pc4"}, pc4_IF_out, exp_pc + 32'd4);
            chk({tag, ".inst"}, inst_IF_out, memword(exp_pc));
        end else begin
            chk({tag, ".inst_nop"}, inst_IF_out, NOP);
        end
    endtask

    task automatic cycle(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] rpc);
        cpu_rst     = rst;
        stall_IF    = stall;
        redirect_en = redir;
        redirect_pc = rpc;
        imem_rvalid = m_pend && (m_cnt == 1);
        imem_rdata  = imem_rvalid ? memword(m_addr) : 32'hDEAD_BEEF;
        #1;
        seen_req = imem_req;
        if (imem_req) begin
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
            end else begin
                chk("imem_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (m_pend) begin
            if (m_cnt == 1) m_pend = 1'b0;
            else            m_cnt--;
        end
        if (imem_req) begin
            m_pend = 1'b1;
            m_addr = imem_addr;
            m_cnt  = lat;
        end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic chk_req(input string name, input logic exp);
        chk(name, {31'd0, seen_req}, {31'd0, exp});
    endtask

    initial begin
        cpu_rst     = 1'b1;
        stall_IF    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        //            stall redir rpc          req addr         valid pc
        tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'hC};
        tbl[11] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40};
        tbl[14] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40};

        @(negedge cpu_clk);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk_req("rst_req0", 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk_req("rst_req1", 1'b0);
        chk("rst.valid", {31'd0, inst_valid_IF_out}, 32'd0);
        chk("rst.pc", pc_IF_out, 32'h0);
        chk("rst.pc4", pc4_IF_out, 32'h4);
        chk("rst.inst", inst_IF_out, NOP);

        // Sequential fetch, a 3-cycle stall and a redirect, memory latency 1.
        lat = 1;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].exp_req) addr_q.push_back(tbl[i].exp_addr);
            cycle(1'b0, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            chk_req($sformatf("tbl%0d.req", i), tbl[i].exp_req);
            check_slot($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_pc);
        end

        // Latency 3: redirect one cycle after the request to 0x10.
        lat = 3;
        addr_q.push_back(32'h10);
        addr_q.push_back(32'h100);
        cycle(1'b0, 1'b0, 1'b1, 32'h10);
        check_slot("kill.c1", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("kill.req10", 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h100);
        check_slot("kill.c3", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("kill.c4_noreq", 1'b0);
        check_slot("kill.c4", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("kill.c5_noreq", 1'b0);
        check_slot("kill.c5_dropped", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("kill.req100", 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("kill.c8", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("kill.c9", 1'b1, 32'h100);

        // Redirect coinciding with the response in WAIT: no KILL cycle.
        lat = 1;
        addr_q.push_back(32'h104);
        addr_q.push_back(32'h200);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("rdrv.req104", 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h203);
        chk_req("rdrv.noreq", 1'b0);
        check_slot("rdrv.drop", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("rdrv.req200", 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("rdrv.load", 1'b1, 32'h200);

        // Redirect while the slot is full and stalled.
        addr_q.push_back(32'h300);
        cycle(1'b0, 1'b1, 1'b1, 32'h300);
        chk_req("rstl.noreq", 1'b0);
        check_slot("rstl.clear", 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk_req("rstl.req300", 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_slot("rstl.load", 1'b1, 32'h300);

        // Fetch PC wraps from the top of the address space.
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check_slot("wrap.clear", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("wrap.req_top", 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("wrap.top", 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("wrap.req0", 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("wrap.zero", 1'b1, 32'h0);

        // Reset while WAIT; the late response lands during reset.
        lat = 2;
        addr_q.push_back(32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("mrst.req4", 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk_req("mrst.noreq0", 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk_req("mrst.noreq1", 1'b0);
        chk("mrst.valid", {31'd0, inst_valid_IF_out}, 32'd0);
        chk("mrst.pc", pc_IF_out, 32'h0);
        chk("mrst.pc4", pc4_IF_out, 32'h4);
        chk("mrst.inst", inst_IF_out, NOP);
        addr_q.push_back(32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk_req("mrst.req_reset_pc", 1'b1);
        check_slot("mrst.c4", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("mrst.c5", 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_slot("mrst.c6", 1'b1, 32'h0);

        chk("addr_q_drained", addr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
